// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues one outstanding request
// at a time to instruction memory, buffers returned words in a prefetch FIFO
// and hands them to decode over a valid/ready handshake.
// Ports:
//   CLK, RESET_N          clock, async active-low reset
//   IMEM_REQ/ADDR         fetch request and address (held until IMEM_ACK)
//   IMEM_ACK/RDATA        request accepted, instruction word valid this cycle
//   ID_VALID/READY        decode handshake on the FIFO head
//   ID_INSTR/ID_PC        head instruction word and its address
//   OPCODE/RC/RA/RB/LITERAL  decoded fields of ID_INSTR
//   PCSEL, BR_TARGET, JMP_TARGET  redirect request from the decoder
module instr_fetch_unit #(
  parameter int unsigned       ADDR_W       = 32,
  parameter int unsigned       FIFO_DEPTH   = 4,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter logic [ADDR_W-1:0] ILLOP_VECTOR = ADDR_W'(32'h4),
  parameter logic [ADDR_W-1:0] XADR_VECTOR  = ADDR_W'(32'h8)
) (
  input  logic              CLK,
  input  logic              RESET_N,
  output logic              IMEM_REQ,
  output logic [ADDR_W-1:0] IMEM_ADDR,
  input  logic              IMEM_ACK,
  input  logic [31:0]       IMEM_RDATA,
  output logic              ID_VALID,
  input  logic              ID_READY,
  output logic [31:0]       ID_INSTR,
  output logic [ADDR_W-1:0] ID_PC,
  output logic [5:0]        OPCODE,
  output logic [4:0]        RC,
  output logic [4:0]        RA,
  output logic [4:0]        RB,
  output logic [15:0]       LITERAL,
  input  logic [2:0]        PCSEL,
  input  logic [ADDR_W-1:0] BR_TARGET,
  input  logic [ADDR_W-1:0] JMP_TARGET
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DISCARD} state_t;

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_pc, w_pc_nxt;
  logic                r_req, w_req_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic [PTR_W-1:0]    r_wptr, w_wptr_nxt, r_rptr, w_rptr_nxt, w_rptr_ap;
  logic [CNT_W-1:0]    r_count, w_count_nxt, w_cnt_ap;
  logic                r_id_valid, w_id_valid_nxt;
  logic [31:0]         r_id_instr, w_id_instr_nxt;
  logic [ADDR_W-1:0]   r_id_pc, w_id_pc_nxt;
  logic [31:0]         r_mem_instr [FIFO_DEPTH];
  logic [ADDR_W-1:0]   r_mem_pc    [FIFO_DEPTH];

  logic                w_redir, w_ack, w_pop, w_push;
  logic [ADDR_W-1:0]   w_target, w_pc_inc;

  // Redirect decode; codes 5-7 behave like "no redirect".
  always_comb begin
    w_redir  = 1'b0;
    w_target = r_pc;
    case (PCSEL)
      3'd1: begin w_redir = 1'b1; w_target = BR_TARGET; end
      3'd2: begin w_redir = 1'b1; w_target = JMP_TARGET & ~ADDR_W'(3); end
      3'd3: begin w_redir = 1'b1; w_target = ILLOP_VECTOR; end
      3'd4: begin w_redir = 1'b1; w_target = XADR_VECTOR; end
      default: ;
    endcase
  end

  // Handshake qualifiers; a redirect suppresses both push and pop.
  always_comb begin
    w_ack     = r_req & IMEM_ACK;
    w_pop     = r_id_valid & ID_READY & ~w_redir;
    w_push    = (r_state == S_REQ) & w_ack & ~w_redir;
    w_cnt_ap  = r_count - CNT_W'(w_pop);
    w_rptr_ap = r_rptr + PTR_W'(w_pop);
    w_pc_inc  = r_addr + ADDR_W'(4);
  end

  // Fetch FSM next state; request/address are registered outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_req_nxt   = r_req;
    w_addr_nxt  = r_addr;
    if (w_redir) begin
      w_pc_nxt = w_target;
      if ((r_state != S_IDLE) && !w_ack) begin
        // Outstanding request must still complete; its data will be dropped.
        w_state_nxt = S_DISCARD;
      end else begin
        w_state_nxt = S_IDLE;
        w_req_nxt   = 1'b0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_cnt_ap < CNT_W'(FIFO_DEPTH)) begin
            w_state_nxt = S_REQ;
            w_req_nxt   = 1'b1;
            w_addr_nxt  = r_pc;
          end
        end
        S_REQ: begin
          if (w_ack) begin
            w_pc_nxt = w_pc_inc;
            if ((w_cnt_ap + CNT_W'(1)) < CNT_W'(FIFO_DEPTH)) begin
              w_addr_nxt = w_pc_inc;
            end else begin
              w_state_nxt = S_IDLE;
              w_req_nxt   = 1'b0;
            end
          end
        end
        S_DISCARD: begin
          if (w_ack) begin
            w_state_nxt = S_IDLE;
            w_req_nxt   = 1'b0;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_req_nxt   = 1'b0;
        end
      endcase
    end
  end

  // FIFO pointers and registered head; head bypasses storage when FIFO drains.
  always_comb begin
    w_wptr_nxt     = r_wptr;
    w_rptr_nxt     = r_rptr;
    w_count_nxt    = r_count;
    w_id_valid_nxt = r_id_valid;
    w_id_instr_nxt = r_id_instr;
    w_id_pc_nxt    = r_id_pc;
    if (w_redir) begin
      w_wptr_nxt     = '0;
      w_rptr_nxt     = '0;
      w_count_nxt    = '0;
      w_id_valid_nxt = 1'b0;
    end else begin
      w_wptr_nxt     = r_wptr + PTR_W'(w_push);
      w_rptr_nxt     = w_rptr_ap;
      w_count_nxt    = w_cnt_ap + CNT_W'(w_push);
      w_id_valid_nxt = (w_count_nxt != '0);
      if (w_cnt_ap != '0) begin
        w_id_instr_nxt = r_mem_instr[w_rptr_ap];
        w_id_pc_nxt    = r_mem_pc[w_rptr_ap];
      end else if (w_push) begin
        w_id_instr_nxt = IMEM_RDATA;
        w_id_pc_nxt    = r_addr;
      end
    end
  end

  // State registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_VECTOR;
      r_req      <= 1'b0;
      r_addr     <= RESET_VECTOR;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_id_valid <= 1'b0;
      r_id_instr <= '0;
      r_id_pc    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_req      <= w_req_nxt;
      r_addr     <= w_addr_nxt;
      r_wptr     <= w_wptr_nxt;
      r_rptr     <= w_rptr_nxt;
      r_count    <= w_count_nxt;
      r_id_valid <= w_id_valid_nxt;
      r_id_instr <= w_id_instr_nxt;
      r_id_pc    <= w_id_pc_nxt;
    end
  end

  // Prefetch storage; contents are only read while the entry is live.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem_instr[r_wptr] <= IMEM_RDATA;
      r_mem_pc[r_wptr]    <= r_addr;
    end
  end

  assign IMEM_REQ  = r_req;
  assign IMEM_ADDR = r_addr;
  assign ID_VALID  = r_id_valid;
  assign ID_INSTR  = r_id_instr;
  assign ID_PC     = r_id_pc;
  assign OPCODE    = r_id_instr[31:26];
  assign RC        = r_id_instr[25:21];
  assign RA        = r_id_instr[20:16];
  assign RB        = r_id_instr[15:11];
  assign LITERAL   = r_id_instr[15:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: vector table plus scoreboard.
module tb_instr_fetch_unit;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b1;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_ACK = 1'b0;
  logic [31:0] IMEM_RDATA = '0;
  logic        ID_VALID;
  logic        ID_READY = 1'b0;
  logic [31:0] ID_INSTR;
  logic [31:0] ID_PC;
  logic [5:0]  OPCODE;
  logic [4:0]  RC, RA, RB;
  logic [15:0] LITERAL;
  logic [2:0]  PCSEL = '0;
  logic [31:0] BR_TARGET = '0;
  logic [31:0] JMP_TARGET = '0;

  always #5 CLK = ~CLK;

  instr_fetch_unit dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR),
    .IMEM_ACK(IMEM_ACK), .IMEM_RDATA(IMEM_RDATA),
    .ID_VALID(ID_VALID), .ID_READY(ID_READY),
    .ID_INSTR(ID_INSTR), .ID_PC(ID_PC),
    .OPCODE(OPCODE), .RC(RC), .RA(RA), .RB(RB), .LITERAL(LITERAL),
    .PCSEL(PCSEL), .BR_TARGET(BR_TARGET), .JMP_TARGET(JMP_TARGET)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } sb_t;

  typedef struct {
    logic        ack;
    logic        rdy;
    logic [2:0]  sel;
    logic [31:0] tgt;
    logic        ereq;
    logic [31:0] eaddr;
    logic        evalid;
  } vec_t;

  localparam int NVEC = 34;

  sb_t         sb[$];
  vec_t        vecs[NVEC];
  int          errors = 0;
  int          checks = 0;
  logic        disc = 1'b0;
  logic [31:0] exp_pc = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h8041_0000;
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_v(input int i, input logic ack, input logic rdy, input logic [2:0] sel,
                       input logic [31:0] tgt, input logic ereq, input logic [31:0] eaddr,
                       input logic evalid);
    vecs[i] = '{ack, rdy, sel, tgt, ereq, eaddr, evalid};
  endtask

  // One clock: drive inputs, update the model, advance, check ID_VALID.
  task automatic step(input logic ack, input logic rdy, input logic [2:0] sel,
                      input logic [31:0] tgt);
    logic redir;
    logic ack_now;
    sb_t  e;
    if (IMEM_REQ && !disc) chk("imem_addr_model", IMEM_ADDR, exp_pc);
    redir      = (sel >= 3'd1) && (sel <= 3'd4);
    ack_now    = ack & IMEM_REQ;
    IMEM_ACK   = ack_now;
    IMEM_RDATA = mem_word(IMEM_ADDR);
    ID_READY   = rdy;
    PCSEL      = sel;
    BR_TARGET  = tgt;
    JMP_TARGET = tgt;
    if (redir) begin
      sb.delete();
      disc = IMEM_REQ && !ack_now;
      case (sel)
        3'd1:    exp_pc = tgt;
        3'd2:    exp_pc = {tgt[31:2], 2'b00};
        3'd3:    exp_pc = 32'h4;
        default: exp_pc = 32'h8;
      endcase
    end else begin
      if (ID_VALID && rdy) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_unexpected actual=ID_VALID=1 expected=empty at %0t", $time);
        end else begin
          e = sb.pop_front();
          chk("id_pc", ID_PC, e.pc);
          chk("id_instr", ID_INSTR, e.instr);
          chk("opcode", 32'(OPCODE), 32'(e.instr[31:26]));
          chk("literal", 32'(LITERAL), 32'(e.instr[15:0]));
        end
      end
      if (ack_now) begin
        if (disc) disc = 1'b0;
        else begin
          sb.push_back('{exp_pc, mem_word(exp_pc)});
          exp_pc = exp_pc + 32'h4;
        end
      end
    end
    @(posedge CLK);
    #1;
    IMEM_ACK = 1'b0;
    chk("id_valid_sb", 32'(ID_VALID), 32'(sb.size() != 0));
  endtask

  task automatic clear_model();
    sb.delete();
    disc   = 1'b0;
    exp_pc = 32'h0;
  endtask

  initial begin
    //     i  ack rdy sel  tgt            req  addr           valid
    set_v( 0, 0, 0, 3'd0, 32'h0,        1, 32'h0,        0);
    set_v( 1, 1, 0, 3'd0, 32'h0,        1, 32'h4,        1);
    set_v( 2, 1, 0, 3'd0, 32'h0,        1, 32'h8,        1);
    set_v( 3, 1, 0, 3'd0, 32'h0,        1, 32'hC,        1);
    set_v( 4, 1, 0, 3'd0, 32'h0,        0, 32'h0,        1);
    set_v( 5, 1, 0, 3'd0, 32'h0,        0, 32'h0,        1);
    set_v( 6, 0, 1, 3'd0, 32'h0,        1, 32'h10,       1);
    set_v( 7, 0, 1, 3'd0, 32'h0,        1, 32'h10,       1);
    set_v( 8, 0, 1, 3'd0, 32'h0,        1, 32'h10,       1);
    set_v( 9, 0, 1, 3'd0, 32'h0,        1, 32'h10,       0);
    set_v(10, 1, 0, 3'd0, 32'h0,        1, 32'h14,       1);
    set_v(11, 0, 0, 3'd1, 32'h100,      1, 32'h14,       0);
    set_v(12, 0, 0, 3'd0, 32'h0,        1, 32'h14,       0);
    set_v(13, 1, 0, 3'd0, 32'h0,        0, 32'h0,        0);
    set_v(14, 0, 0, 3'd0, 32'h0,        1, 32'h100,      0);
    set_v(15, 1, 0, 3'd2, 32'h203,      0, 32'h0,        0);
    set_v(16, 0, 0, 3'd0, 32'h0,        1, 32'h200,      0);
    set_v(17, 1, 0, 3'd0, 32'h0,        1, 32'h204,      1);
    set_v(18, 1, 0, 3'd1, 32'hFFFFFFFC, 0, 32'h0,        0);
    set_v(19, 0, 0, 3'd0, 32'h0,        1, 32'hFFFFFFFC, 0);
    set_v(20, 1, 0, 3'd0, 32'h0,        1, 32'h0,        1);
    set_v(21, 1, 0, 3'd3, 32'h0,        0, 32'h0,        0);
    set_v(22, 0, 0, 3'd0, 32'h0,        1, 32'h4,        0);
    set_v(23, 1, 0, 3'd4, 32'h0,        0, 32'h0,        0);
    set_v(24, 0, 0, 3'd0, 32'h0,        1, 32'h8,        0);
    set_v(25, 1, 0, 3'd5, 32'h500,      1, 32'hC,        1);
    set_v(26, 0, 1, 3'd7, 32'h0,        1, 32'hC,        0);
    set_v(27, 1, 1, 3'd0, 32'h0,        1, 32'h10,       1);
    set_v(28, 1, 1, 3'd0, 32'h0,        1, 32'h14,       1);
    set_v(29, 1, 1, 3'd0, 32'h0,        1, 32'h18,       1);
    set_v(30, 0, 1, 3'd1, 32'h300,      1, 32'h18,       0);
    set_v(31, 0, 0, 3'd2, 32'h400,      1, 32'h18,       0);
    set_v(32, 1, 0, 3'd0, 32'h0,        0, 32'h0,        0);
    set_v(33, 0, 0, 3'd0, 32'h0,        1, 32'h400,      0);

    // Reset state.
    #2 RESET_N = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_imem_req", 32'(IMEM_REQ), 32'h0);
    chk("rst_imem_addr", IMEM_ADDR, 32'h0);
    chk("rst_id_valid", 32'(ID_VALID), 32'h0);
    chk("rst_id_instr", ID_INSTR, 32'h0);
    chk("rst_id_pc", ID_PC, 32'h0);
    RESET_N = 1'b1;
    clear_model();

    for (int i = 0; i < NVEC; i++) begin
      step(vecs[i].ack, vecs[i].rdy, vecs[i].sel, vecs[i].tgt);
      chk($sformatf("v%0d_imem_req", i), 32'(IMEM_REQ), 32'(vecs[i].ereq));
      if (vecs[i].ereq) chk($sformatf("v%0d_imem_addr", i), IMEM_ADDR, vecs[i].eaddr);
      chk($sformatf("v%0d_id_valid", i), 32'(ID_VALID), 32'(vecs[i].evalid));
      if (i == 1) begin
        chk("t1_opcode", 32'(OPCODE), 32'h20);
        chk("t1_rc", 32'(RC), 32'h2);
        chk("t1_ra", 32'(RA), 32'h1);
        chk("t1_rb", 32'(RB), 32'h0);
        chk("t1_literal", 32'(LITERAL), 32'h0);
        chk("t1_id_pc", ID_PC, 32'h0);
      end
    end

    // Mid-request reset with three buffered entries.
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 3'd0, 32'h0);
    chk("t6_pre_req", 32'(IMEM_REQ), 32'h1);
    chk("t6_pre_addr", IMEM_ADDR, 32'h40C);
    #2 RESET_N = 1'b0;
    #1;
    chk("t6_req_drop", 32'(IMEM_REQ), 32'h0);
    chk("t6_valid_drop", 32'(ID_VALID), 32'h0);
    repeat (2) @(posedge CLK);
    #1;
    RESET_N = 1'b1;
    clear_model();
    step(1'b0, 1'b0, 3'd0, 32'h0);
    chk("t6_first_req", 32'(IMEM_REQ), 32'h1);
    chk("t6_first_addr", IMEM_ADDR, 32'h0);
    step(1'b1, 1'b1, 3'd0, 32'h0);
    step(1'b0, 1'b1, 3'd0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
